// File: rtl/prog_udp_lut.sv
// prog_udp_lut: programmable N_IN-input truth-table lookup (UDP-style LUT).
// The active table is reloaded serially through a shadow register. The new
// table only takes effect once every bit has arrived, so a partial or aborted
// load never disturbs the running function. Lookups use a valid/ready
// handshake with one register stage. The output stage holds its result under
// back-pressure.
// Optional feature: define PROG_UDP_LUT_HITCNT_EN to add the 16-bit
// saturating hit_count output. It counts handshaked results with out_y=1.
module prog_udp_lut #(
  parameter int                   N_IN       = 4,
  parameter logic [(2**N_IN)-1:0] INIT_TABLE = 16'hCE40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_y,
`ifdef PROG_UDP_LUT_HITCNT_EN
  output logic [15:0]     hit_count,
`endif
  input  logic            out_ready
);

  localparam int              DEPTH    = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [N_IN-1:0]   r_cnt;
  logic [N_IN-1:0]   w_cnt_next;
  logic [DEPTH-1:0]  r_shadow;
  logic [DEPTH-1:0]  w_shadow_wr;
  logic [DEPTH-1:0]  r_table;
  logic              w_shadow_we;
  logic              w_commit;
  logic              r_cfg_done;
  logic              r_out_valid;
  logic              r_out_y;
  logic              w_accept;

  // The shadow contents with the current bit merged in at position r_cnt.
  // The commit path reuses this value, so the final bit reaches the active
  // table on the same edge that it is written.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shadow_bit
      assign w_shadow_wr[gi] = (r_cnt == N_IN'(gi)) ? cfg_bit : r_shadow[gi];
    end
  endgenerate

  // FSM next-state logic: cfg_start always restarts a load (even mid-load),
  // and it takes priority over a bit offered in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shadow_we  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (cfg_start) begin
          w_state_next = ST_LOAD;
          w_cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_start) begin
          w_cnt_next = '0;
        end else if (cfg_valid) begin
          w_shadow_we = 1'b1;
          w_cnt_next  = r_cnt + N_IN'(1);
          if (r_cnt == LAST_IDX) begin
            w_commit     = 1'b1;
            w_state_next = ST_RUN;
          end
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = '0;
      end
    endcase
  end

  // FSM state and bit-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Shadow table: collects the serial bits of a load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_shadow_we) begin
      r_shadow <= w_shadow_wr;
    end
  end

  // Active table: changes only when a complete load commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_table <= INIT_TABLE;
    end else if (w_commit) begin
      r_table <= w_shadow_wr;
    end
  end

  // Single-cycle load-complete pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= w_commit;
    end
  end

  // Lookups are accepted only in RUN, and only when the output slot is free
  // or is being drained in this cycle.
  assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output register: a new result replaces the current one. A drained slot
  // with no new input goes empty. Otherwise the result is held, so a result
  // captured before a load still shows the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_y     <= r_table[in_vec];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PROG_UDP_LUT_HITCNT_EN
  logic [15:0] r_hit_count;
  logic        w_out_hit;

  assign w_out_hit = r_out_valid && out_ready && r_out_y;

  // Hit counter: cleared when a new table commits, and saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count <= '0;
    end else if (w_commit) begin
      r_hit_count <= '0;
    end else if (w_out_hit && (r_hit_count != 16'hFFFF)) begin
      r_hit_count <= r_hit_count + 16'd1;
    end
  end

  assign hit_count = r_hit_count;
`endif

  assign cfg_busy  = (r_state == ST_LOAD);
  assign cfg_done  = r_cfg_done;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_prog_udp_lut.sv
// Directed testbench for prog_udp_lut with a scoreboard on the result stream.
module tb_prog_udp_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_y;
  logic       out_ready;
`ifdef PROG_UDP_LUT_HITCNT_EN
  logic [15:0] hit_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   n_out    = 0;
  logic sb[$];
  logic acc_prev = 1'b0;

  // Reference model state: either the reset function (as a boolean equation)
  // or a table that the bench loaded itself.
  bit          model_init  = 1'b1;
  logic [15:0] model_table = 16'h0000;

  prog_udp_lut dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_y     (out_y),
`ifdef PROG_UDP_LUT_HITCNT_EN
    .hit_count (hit_count),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    if (model_init) return (a & ~b & d) | (b & c & ~d) | (a & c);
    return model_table[v];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector and hold it until it is accepted (bounded wait).
  task automatic apply_vec(input logic [3:0] v);
    int k;
    k = 0;
    in_vec   = v;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    chk("accept_wait_bound", 32'(k < 50), 1);
    tick();
  endtask

  // Serial load of n bits of 'bits', index 0 first. The opening cfg_start
  // cycle also offers a bit when in_load is set, which must be dropped.
  task automatic load_bits(input logic [15:0] bits, input int n, input bit in_load);
    cfg_start = 1'b1;
    cfg_valid = in_load;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[i];
      chk("cfg_busy_in_load", 32'(cfg_busy), 1);
      chk("in_ready_in_load", 32'(in_ready), 0);
      tick();
    end
    cfg_valid = 1'b0;
    if (n == 16) begin
      model_init  = 1'b0;
      model_table = bits;
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle, it sees the handshakes about to
  // happen on the next rising edge. The handshake about to drain is popped
  // before the new accept is pushed.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (cfg_done) done_cnt++;
      if (acc_prev) chk("latency1_out_valid", 32'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(sb.size()), 1);
        end else begin
          chk("out_y", 32'(out_y), 32'(sb.pop_front()));
          n_out++;
        end
      end
      acc_prev = in_valid && in_ready;
      if (in_valid && in_ready) sb.push_back(model(in_vec));
    end else begin
      acc_prev = 1'b0;
    end
  end

  initial begin
    int          d0;
    logic        held_exp;
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 4'h0;
    out_ready = 1'b1;

    // Reset state.
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_cfg_busy", 32'(cfg_busy), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // Reset function over all 16 vectors, back-to-back.
    for (int v = 0; v < 16; v++) apply_vec(4'(v));
    in_valid = 1'b0;
    tick(); tick();
    chk("sweep_result_count", 32'(n_out), 16);
`ifdef PROG_UDP_LUT_HITCNT_EN
    chk("hit_count_sweep", hit_count, 6);
`endif

    // Back-pressure: result held stable while out_ready=0.
    out_ready = 1'b0;
    apply_vec(4'h9);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_out_y", 32'(out_y), 32'(model(4'h9)));
      chk("hold_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("drop_out_valid", 32'(out_valid), 0);

    // Held result across a full load keeps the old-table value; table 8000.
    out_ready = 1'b0;
    held_exp  = model(4'h6);
    apply_vec(4'h6);
    in_valid = 1'b0;
    d0 = done_cnt;
    load_bits(16'h8000, 16, 1'b0);
    tick();
    chk("load1_done_pulses", 32'(done_cnt - d0), 1);
    chk("held_out_valid", 32'(out_valid), 1);
    chk("held_old_table_y", 32'(out_y), 32'(held_exp));
`ifdef PROG_UDP_LUT_HITCNT_EN
    chk("hit_count_after_load", hit_count, 0);
`endif
    out_ready = 1'b1;
    apply_vec(4'hF);
    apply_vec(4'h9);
    in_valid = 1'b0;
    tick(); tick();

    // Aborted load followed by a full reload of 0001.
    d0 = done_cnt;
    load_bits(16'hFFFF, 7, 1'b0);
    chk("partial_no_done", 32'(done_cnt - d0), 0);
    load_bits(16'h0001, 16, 1'b1);
    tick(); tick();
    chk("load2_done_pulses", 32'(done_cnt - d0), 1);
    apply_vec(4'h0);
    apply_vec(4'hF);
    in_valid = 1'b0;
    tick();

    // cfg_valid without cfg_start in RUN is ignored.
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_cfg_valid_busy", 32'(cfg_busy), 0);
    end
    cfg_valid = 1'b0;
    apply_vec(4'h0);
    apply_vec(4'h5);
    in_valid = 1'b0;
    tick(); tick();

    // Reset mid-load restores the initial table.
    load_bits(16'h0000, 10, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_busy", 32'(cfg_busy), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    model_init = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("in_ready_after_rst2", 32'(in_ready), 1);
    apply_vec(4'h6);
    apply_vec(4'h8);
    apply_vec(4'hF);
    in_valid = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
